// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, looks it up in the I-cache,
// refills misses byte by byte from memory and hands instructions to decode.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        id_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] ic_raddr_o,
    input  logic        ic_hit_i,
    input  logic [31:0] ic_inst_i,
    output logic        ic_we_o,
    output logic [31:0] ic_waddr_o,
    output logic [31:0] ic_winst_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_data_i
);

    typedef enum logic [1:0] {LOOKUP, FILL, WB} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;
    logic [31:0] fill_buf, fill_buf_nxt;
    logic        valid_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] pc_out_nxt;
    logic        out_free;

    assign out_free   = !inst_valid_o || id_ready_i;
    assign ic_raddr_o = pc;
    assign ic_waddr_o = pc;
    assign ic_winst_o = fill_buf;
    assign mem_addr_o = pc + {30'b0, byte_cnt};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= LOOKUP;
            pc           <= RESET_PC;
            byte_cnt     <= 2'd0;
            fill_buf     <= 32'h0;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'h0;
            pc_o         <= 32'h0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            byte_cnt     <= byte_cnt_nxt;
            fill_buf     <= fill_buf_nxt;
            inst_valid_o <= valid_nxt;
            inst_o       <= inst_nxt;
            pc_o         <= pc_out_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        byte_cnt_nxt = byte_cnt;
        fill_buf_nxt = fill_buf;
        valid_nxt    = inst_valid_o;
        inst_nxt     = inst_o;
        pc_out_nxt   = pc_o;
        mem_req_o    = 1'b0;
        ic_we_o      = 1'b0;
        if (rdy) begin
            if (inst_valid_o && id_ready_i)
                valid_nxt = 1'b0;
            unique case (state)
                LOOKUP: begin
                    if (ic_hit_i) begin
                        if (out_free) begin
                            inst_nxt   = ic_inst_i;
                            pc_out_nxt = pc;
                            valid_nxt  = 1'b1;
                            pc_nxt     = pc + 32'd4;
                        end
                    end else begin
                        state_nxt    = FILL;
                        byte_cnt_nxt = 2'd0;
                    end
                end
                FILL: begin
                    mem_req_o = 1'b1;
                    if (mem_ack_i) begin
                        fill_buf_nxt[{byte_cnt, 3'b000} +: 8] = mem_data_i;
                        byte_cnt_nxt = byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3)
                            state_nxt = WB;
                    end
                end
                WB: begin
                    ic_we_o   = 1'b1;
                    state_nxt = LOOKUP;
                    if (out_free) begin
                        inst_nxt   = fill_buf;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + 32'd4;
                    end
                end
                default: state_nxt = LOOKUP;
            endcase
            // A redirect wins over any load or fill progress this cycle
            if (jump_i) begin
                pc_nxt       = {jump_addr_i[31:2], 2'b00};
                valid_nxt    = 1'b0;
                state_nxt    = LOOKUP;
                byte_cnt_nxt = 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle checks, then a randomized run
// scored against an instruction-stream model with cache and memory models.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        id_ready_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] ic_raddr_o;
    logic        ic_hit_i;
    logic [31:0] ic_inst_i;
    logic        ic_we_o;
    logic [31:0] ic_waddr_o;
    logic [31:0] ic_winst_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_data_i;

    logic        use_model;
    logic        cache_clr;
    logic        d_hit;
    logic [31:0] d_inst;
    logic [255:0] cvalid;
    logic [31:0] ctag  [256];
    logic [31:0] cdata [256];

    int n_cmp = 0;
    int n_bad = 0;

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .id_ready_i(id_ready_i), .inst_valid_o(inst_valid_o),
        .inst_o(inst_o), .pc_o(pc_o), .ic_raddr_o(ic_raddr_o),
        .ic_hit_i(ic_hit_i), .ic_inst_i(ic_inst_i),
        .ic_we_o(ic_we_o), .ic_waddr_o(ic_waddr_o),
        .ic_winst_o(ic_winst_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h[23:16] ^ a[7:0];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {byte_at(a + 32'd3), byte_at(a + 32'd2),
                byte_at(a + 32'd1), byte_at(a)};
    endfunction

    // Direct-mapped cache model, filled only by the DUT's writes
    always @(posedge clk) begin
        if (cache_clr) begin
            cvalid <= '0;
        end else if (ic_we_o) begin
            cvalid[ic_waddr_o[9:2]] <= 1'b1;
            ctag[ic_waddr_o[9:2]]   <= ic_waddr_o;
            cdata[ic_waddr_o[9:2]]  <= ic_winst_o;
        end
    end

    always_comb begin
        ic_hit_i  = d_hit;
        ic_inst_i = d_inst;
        if (use_model) begin
            ic_hit_i  = cvalid[ic_raddr_o[9:2]] &&
                        ctag[ic_raddr_o[9:2]] == ic_raddr_o;
            ic_inst_i = cdata[ic_raddr_o[9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic ack_byte(input logic [7:0] d);
        mem_ack_i  = 1'b1;
        mem_data_i = d;
        tick();
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        prev_jump;
        int          consumed;

        use_model   = 1'b0;
        cache_clr   = 1'b1;
        rst         = 1'b0;
        rdy         = 1'b1;
        jump_i      = 1'b0;
        jump_addr_i = 32'h0;
        id_ready_i  = 1'b1;
        d_hit       = 1'b1;
        d_inst      = 32'h00000013;
        mem_ack_i   = 1'b0;
        mem_data_i  = 8'h0;

        // reset and back-to-back hits
        @(negedge clk);
        tick();
        chk("rst_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc_o", pc_o, 32'h0);
        chk("rst_raddr", ic_raddr_o, 32'h0);
        chk("rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_we", {31'b0, ic_we_o}, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hit_valid", {31'b0, inst_valid_o}, 32'h1);
            chk("hit_pc_o", pc_o, 32'(i * 4));
            chk("hit_inst", inst_o, 32'h00000013);
        end

        // miss at 0x100 with ack every cycle
        jump_i = 1'b1;
        jump_addr_i = 32'h100;
        d_hit = 1'b0;
        tick();
        jump_i = 1'b0;
        chk("jmp_valid", {31'b0, inst_valid_o}, 32'h0);
        chk("jmp_raddr", ic_raddr_o, 32'h100);
        tick();
        chk("fill_req", {31'b0, mem_req_o}, 32'h1);
        chk("fill_addr0", mem_addr_o, 32'h100);
        ack_byte(8'h13);
        chk("fill_addr1", mem_addr_o, 32'h101);
        ack_byte(8'h05);
        ack_byte(8'h00);
        chk("fill_addr3", mem_addr_o, 32'h103);
        ack_byte(8'h00);
        mem_ack_i = 1'b0;
        chk("wb_we", {31'b0, ic_we_o}, 32'h1);
        chk("wb_req", {31'b0, mem_req_o}, 32'h0);
        chk("wb_waddr", ic_waddr_o, 32'h100);
        chk("wb_winst", ic_winst_o, 32'h00000513);
        tick();
        chk("wb_we_off", {31'b0, ic_we_o}, 32'h0);
        chk("fill_valid", {31'b0, inst_valid_o}, 32'h1);
        chk("fill_inst", inst_o, 32'h00000513);
        chk("fill_pc_o", pc_o, 32'h100);
        chk("fill_next", ic_raddr_o, 32'h104);

        // decode stall holds the output register and pc
        d_hit = 1'b1;
        d_inst = 32'hAAAA0001;
        id_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc_o", pc_o, 32'h100);
            chk("stall_inst", inst_o, 32'h00000513);
            chk("stall_raddr", ic_raddr_o, 32'h104);
        end
        id_ready_i = 1'b1;
        tick();
        chk("unstall_pc_o", pc_o, 32'h104);
        chk("unstall_inst", inst_o, 32'hAAAA0001);

        // jump during a partial fill at 0x40
        d_hit = 1'b0;
        jump_i = 1'b1;
        jump_addr_i = 32'h40;
        tick();
        jump_i = 1'b0;
        tick();
        ack_byte(8'h11);
        ack_byte(8'h22);
        chk("part_addr", mem_addr_o, 32'h42);
        jump_i = 1'b1;
        jump_addr_i = 32'h200;
        mem_data_i = 8'h33;
        tick();
        jump_i = 1'b0;
        mem_ack_i = 1'b0;
        chk("jf_req", {31'b0, mem_req_o}, 32'h0);
        chk("jf_we", {31'b0, ic_we_o}, 32'h0);
        chk("jf_raddr", ic_raddr_o, 32'h200);
        tick();
        chk("jf_addr0", mem_addr_o, 32'h200);

        // rdy=0 freeze mid-fill
        ack_byte(8'h78);
        ack_byte(8'h56);
        rdy = 1'b0;
        mem_data_i = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            id_ready_i = i[0];
            tick();
            chk("frz_req", {31'b0, mem_req_o}, 32'h0);
            chk("frz_addr", mem_addr_o, 32'h202);
            chk("frz_valid", {31'b0, inst_valid_o}, 32'h0);
        end
        rdy = 1'b1;
        id_ready_i = 1'b1;
        mem_ack_i = 1'b0;
        #1;
        chk("res_req", {31'b0, mem_req_o}, 32'h1);
        chk("res_addr", mem_addr_o, 32'h202);
        ack_byte(8'h34);
        ack_byte(8'h12);
        mem_ack_i = 1'b0;
        chk("res_winst", ic_winst_o, 32'h12345678);
        chk("res_waddr", ic_waddr_o, 32'h200);
        tick();
        chk("res_inst", inst_o, 32'h12345678);
        chk("res_pc_o", pc_o, 32'h200);

        // pc wrap and jump target alignment
        jump_i = 1'b1;
        jump_addr_i = 32'hFFFFFFFE;
        d_hit = 1'b1;
        d_inst = 32'h0000CAFE;
        tick();
        jump_i = 1'b0;
        chk("wrap_raddr", ic_raddr_o, 32'hFFFFFFFC);
        tick();
        chk("wrap_pc_o", pc_o, 32'hFFFFFFFC);
        chk("wrap_next", ic_raddr_o, 32'h0);
        jump_i = 1'b1;
        jump_addr_i = 32'h203;
        tick();
        jump_i = 1'b0;
        chk("align_raddr", ic_raddr_o, 32'h200);

        // reset mid-fill
        d_hit = 1'b0;
        tick();
        ack_byte(8'h01);
        mem_ack_i = 1'b0;
        rst = 1'b0;
        tick();
        chk("rfill_raddr", ic_raddr_o, 32'h0);
        chk("rfill_req", {31'b0, mem_req_o}, 32'h0);
        chk("rfill_we", {31'b0, ic_we_o}, 32'h0);

        // randomized run against the stream model
        use_model = 1'b1;
        tick();
        cache_clr = 1'b0;
        rst = 1'b1;
        exp_pc = 32'h0;
        prev_jump = 1'b0;
        consumed = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_jump)
                chk("rj_valid", {31'b0, inst_valid_o}, 32'h0);
            rdy = ($urandom % 8) != 0;
            id_ready_i = ($urandom % 3) != 0;
            jump_i = ($urandom % 40) == 0;
            jump_addr_i = $urandom_range(0, 32'h3FF);
            #1;
            mem_ack_i = mem_req_o && ($urandom % 2 == 0);
            mem_data_i = byte_at(mem_addr_o);
            #1;
            if (rdy && inst_valid_o && id_ready_i) begin
                chk("r_pc_o", pc_o, exp_pc);
                chk("r_inst", inst_o, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (ic_we_o)
                chk("r_winst", ic_winst_o, word_at(ic_waddr_o));
            prev_jump = rdy && jump_i;
            if (prev_jump)
                exp_pc = {jump_addr_i[31:2], 2'b00};
            tick();
        end
        n_cmp++;
        assert (consumed > 100) else begin
            n_bad++;
            $error("FAIL r_progress: got %0d want >100", consumed);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage that owns the PC, looks the PC up in the instruction cache, and on a miss fills the line from the byte-wide memory controller before writing it into the cache. It sits directly upstream of the instruction cache: it drives the cache read address, consumes hit/data, and issues the cache write. It also feeds decode through a one-entry valid/ready output register, and it handles pipeline redirects (jump/branch flush).

## Interface
- RESET_PC, 32'h0, PC value loaded on reset
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-low reset (0 = reset)
- rdy  in  1  global run enable; 0 freezes all state
- jump_i  in  1  redirect request from execute
- jump_addr_i  in  32  redirect target; bits [1:0] ignored (forced 0)
- id_ready_i  in  1  decode accepts inst this cycle
- inst_valid_o  out  1  inst_o/pc_o hold a valid instruction
- inst_o  out  32  fetched instruction
- pc_o  out  32  address of inst_o
- ic_raddr_o  out  32  cache read address (combinational = pc)
- ic_hit_i  in  1  cache hit for ic_raddr_o (combinational)
- ic_inst_i  in  32  cache data for ic_raddr_o
- ic_we_o  out  1  cache write strobe
- ic_waddr_o  out  32  cache write address
- ic_winst_o  out  32  cache write data
- mem_req_o  out  1  byte read request
- mem_addr_o  out  32  byte address requested
- mem_ack_i  in  1  one-cycle pulse; mem_data_i valid for current mem_addr_o
- mem_data_i  in  8  returned byte

## Operation
- State: pc[31:0], state {LOOKUP, FILL, WB}, byte_cnt[1:0], fill buffer buf[31:0], output register (inst_valid_o, inst_o, pc_o).
- Reset (rst=0 at posedge): pc=RESET_PC, state=LOOKUP, byte_cnt=0, buf=0, inst_valid_o=0, inst_o=0, pc_o=0. mem_req_o=0 and ic_we_o=0 follow from the reset state.
- out_free = !inst_valid_o || id_ready_i. Decode consumes when inst_valid_o && id_ready_i. If the register is consumed and not reloaded, inst_valid_o falls to 0.
- LOOKUP: ic_raddr_o=pc.
  - ic_hit_i && out_free: load inst_o=ic_inst_i, pc_o=pc, inst_valid_o=1; pc+=4; stay in LOOKUP.
  - ic_hit_i && !out_free: hold everything.
  - !ic_hit_i: go to FILL with byte_cnt=0.
- FILL: mem_req_o=1, mem_addr_o=pc+byte_cnt.
  - On mem_ack_i: buf[8*byte_cnt+7 : 8*byte_cnt] = mem_data_i (little-endian), byte_cnt++.
  - The ack with byte_cnt=3 moves the block to WB.
- WB: ic_we_o=1, ic_waddr_o=pc, ic_winst_o=buf, for exactly one cycle.
  - If out_free: also load inst_o=buf, pc_o=pc, inst_valid_o=1, pc+=4.
  - Else: pc is unchanged, and the next LOOKUP hits.
  - Next state is LOOKUP in both cases.
- mem_req_o=0 and ic_we_o=0 in all other states. mem_addr_o, ic_waddr_o and ic_winst_o are don't-care while their strobe is low.
- jump_i (highest priority, any state, when rdy=1):
  - pc = {jump_addr_i[31:2],2'b00}, inst_valid_o=0, state=LOOKUP, byte_cnt=0.
  - A mem_ack_i arriving in the same cycle is discarded.
  - A partial fill is never written to the cache; if state is WB the write still completes, since buf is complete.
  - Jump overrides any hit/load in that cycle.
- rdy=0: no register changes. mem_req_o and ic_we_o are forced 0. mem_ack_i and id_ready_i are ignored.
- pc arithmetic wraps modulo 2^32; 32'hFFFFFFFC+4 = 0.

## Timing
- Hit: pc presented in LOOKUP at cycle t → inst_valid_o=1 at t+1. Back-to-back hits with id_ready_i=1 give 1 instruction/cycle.
- Miss with ack every cycle: LOOKUP t, FILL t+1..t+4, WB t+5 (ic_we_o high) → inst_valid_o=1 at t+6.
- Each additional cycle of mem_ack_i latency extends FILL by one cycle. mem_req_o stays high continuously through FILL.
- Output register changes only at posedge. inst_o/pc_o are stable while inst_valid_o=1 && id_ready_i=0.
- Jump asserted at cycle t → inst_valid_o=0 at t+1. The first lookup of the target is at t+1, and its instruction (if hit) is valid at t+2.
- Reset mid-fill: the next cycle is LOOKUP at RESET_PC, mem_req_o=0, and no cache write occurs.

## Test plan
- Reset, then rst=1 with ic_hit_i=1, ic_inst_i=32'h00000013, id_ready_i=1 → inst_valid_o=1 from cycle 2; pc_o=0,4,8 on consecutive cycles.
- Miss at pc=0x100, ack each cycle with bytes 13,05,00,00 → ic_we_o pulse with ic_waddr_o=0x100, ic_winst_o=32'h00000513; inst_o=32'h00000513, pc_o=0x100 the next cycle; next lookup at 0x104.
- Hit with id_ready_i=0 for 3 cycles → inst_o/pc_o held; pc does not advance; on id_ready_i=1, the next instruction loads the following cycle.
- jump_i (target 0x200) after 2 bytes acked during a fill at 0x40 → mem_req_o drops next cycle, no ic_we_o, ic_raddr_o=0x200, and the stale ack is ignored.
- rdy=0 for 5 cycles mid-FILL → byte_cnt, buf and outputs are unchanged, and mem_req_o=0; the fill resumes at the same byte address when rdy=1.
- pc=32'hFFFFFFFC hit → next ic_raddr_o=0; jump_addr_i=0x203 → pc=0x200.
